// File: rtl/code_lock_fsm.sv
// Password-lock controller: hex digit entry, code compare, retry limit and timed lockout.
// Define CODE_LOCK_CHANGE_EN to enable in-field code change via an internal code register.
module code_lock_fsm #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up,
    input  logic                      down,
    input  logic                      cnf,
    input  logic                      back,
    input  logic [4*DIGITS-1:0]       code,
    output logic [4*DIGITS-1:0]       data,
    output logic [$clog2(DIGITS)-1:0] cursor,
    output logic                      pass,
    output logic                      fail,
    output logic                      locked,
    output logic [3:0]                tries_left
);

    localparam int unsigned CurW = $clog2(DIGITS);
    localparam int unsigned CntW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [CurW-1:0] CurTop   = CurW'(DIGITS - 1);
    localparam logic [3:0]      TriesMax = 4'(MAX_TRIES);
    localparam logic [CntW-1:0] CntLoad  = CntW'(LOCKOUT_CYCLES - 1);

    localparam logic [2:0] StEntry   = 3'd0;
    localparam logic [2:0] StPass    = 3'd1;
    localparam logic [2:0] StFail    = 3'd2;
    localparam logic [2:0] StLockout = 3'd3;
`ifdef CODE_LOCK_CHANGE_EN
    localparam logic [2:0] StSet     = 3'd4;
`endif

    logic [2:0]          state_q, state_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [CurW-1:0]     cursor_q, cursor_d;
    logic [3:0]          tries_q, tries_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                pass_q, fail_q, locked_q;
    logic [4*DIGITS-1:0] ref_code;
    logic [3:0]          cur_digit;

`ifdef CODE_LOCK_CHANGE_EN
    logic [4*DIGITS-1:0] code_q, code_d;
    assign ref_code = code_q;
`else
    assign ref_code = code;
`endif

    function automatic logic [3:0] get_digit(input logic [4*DIGITS-1:0] word,
                                             input logic [CurW-1:0]     idx);
        get_digit = 4'h0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == CurW'(i)) get_digit = word[4*i +: 4];
        end
    endfunction

    function automatic logic [4*DIGITS-1:0] set_digit(input logic [4*DIGITS-1:0] word,
                                                      input logic [CurW-1:0]     idx,
                                                      input logic [3:0]          val);
        set_digit = word;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == CurW'(i)) set_digit[4*i +: 4] = val;
        end
    endfunction

    assign cur_digit = get_digit(data_q, cursor_q);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cursor_d = cursor_q;
        tries_d  = tries_q;
        cnt_d    = cnt_q;
`ifdef CODE_LOCK_CHANGE_EN
        code_d   = code_q;
`endif
        case (state_q)
`ifdef CODE_LOCK_CHANGE_EN
            StEntry, StSet: begin
`else
            StEntry: begin
`endif
                // Pulse priority is cnf > back > up > down.
                if (cnf) begin
                    if (cursor_q != '0) begin
                        cursor_d = cursor_q - CurW'(1);
`ifdef CODE_LOCK_CHANGE_EN
                    end else if (state_q == StSet) begin
                        code_d   = data_q;
                        state_d  = StEntry;
                        data_d   = '0;
                        cursor_d = CurTop;
`endif
                    end else if (data_q == ref_code) begin
                        state_d = StPass;
                        tries_d = TriesMax;
                    end else if (tries_q > 4'd1) begin
                        state_d = StFail;
                        tries_d = tries_q - 4'd1;
                    end else begin
                        state_d = StLockout;
                        tries_d = 4'd0;
                        cnt_d   = CntLoad;
                    end
                end else if (back) begin
                    data_d = set_digit(data_q, cursor_q, 4'h0);
                    if (cursor_q != CurTop) cursor_d = cursor_q + CurW'(1);
                end else if (up) begin
                    data_d = set_digit(data_q, cursor_q, cur_digit + 4'd1);
                end else if (down) begin
                    data_d = set_digit(data_q, cursor_q, cur_digit - 4'd1);
                end
            end
            StPass: begin
                if (cnf) begin
                    state_d  = StEntry;
                    data_d   = '0;
                    cursor_d = CurTop;
`ifdef CODE_LOCK_CHANGE_EN
                end else if (back) begin
                    state_d  = StSet;
                    data_d   = '0;
                    cursor_d = CurTop;
`endif
                end
            end
            StFail: begin
                if (cnf) begin
                    state_d  = StEntry;
                    data_d   = '0;
                    cursor_d = CurTop;
                end
            end
            StLockout: begin
                if (cnt_q == '0) begin
                    state_d  = StEntry;
                    data_d   = '0;
                    cursor_d = CurTop;
                    tries_d  = TriesMax;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d  = StEntry;
                data_d   = '0;
                cursor_d = CurTop;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StEntry;
            data_q   <= '0;
            cursor_q <= CurTop;
            tries_q  <= TriesMax;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            locked_q <= 1'b0;
`ifdef CODE_LOCK_CHANGE_EN
            code_q   <= code;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cursor_q <= cursor_d;
            tries_q  <= tries_d;
            cnt_q    <= cnt_d;
            // Flags decoded from the next state so they are true registers, aligned with state.
            pass_q   <= (state_d == StPass);
            fail_q   <= (state_d == StFail) || (state_d == StLockout);
            locked_q <= (state_d == StLockout);
`ifdef CODE_LOCK_CHANGE_EN
            code_q   <= code_d;
`endif
        end
    end

    assign data       = data_q;
    assign cursor     = cursor_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign locked     = locked_q;
    assign tries_left = tries_q;

endmodule
